// File: rtl/seg7_mmio_ctrl.sv
// rtl/seg7_mmio_ctrl.sv - memory-mapped seven-segment display controller
//
// Window of 16 words at BASE_ADDR. Word offsets 0..N_DIGITS-1 are digit
// registers; offset 15 is CTRL {blink_mask[16+:N], read_raw[1], blink_en[0]}.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_lsu_addr           byte address (bits [1:0] ignored)
//   i_st_data            store data
//   i_lsu_wren           store strobe
//   i_lsu_rden           load strobe
//   o_ld_data            load data, one cycle after a hitting load
//   o_ld_valid           load response pulse
//   o_hex_seg            static active-low segments, digit i at [7i+6:7i]
//   o_scan_seg           multiplexed active-low segments
//   o_scan_an            active-low one-hot digit enable for the scan path
module seg7_mmio_ctrl #(
    parameter int          N_DIGITS  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7000,
    parameter int          SCAN_DIV  = 50000,
    parameter int          BLINK_DIV = 25000000
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [31:0]             i_lsu_addr,
    input  logic [31:0]             i_st_data,
    input  logic                    i_lsu_wren,
    input  logic                    i_lsu_rden,
    output logic [31:0]             o_ld_data,
    output logic                    o_ld_valid,
    output logic [7*N_DIGITS-1:0]   o_hex_seg,
    output logic [6:0]              o_scan_seg,
    output logic [N_DIGITS-1:0]     o_scan_an
);

    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [IW-1:0]       IDX_LAST   = IW'(N_DIGITS - 1);
    localparam logic [SW-1:0]       SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0]       BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [4:0]          N_DIG5     = 5'(N_DIGITS);
    localparam logic [N_DIGITS-1:0] AN_ONE     = N_DIGITS'(1);
    localparam logic [6:0]          BLANK      = 7'h7F;
    localparam logic [3:0]          CTRL_OFF   = 4'hF;

    function automatic logic [6:0] hex_enc(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Reverse lookup: table patterns give their nibble, blank gives 0x10,
    // anything written raw that is not in the table reads as all ones.
    function automatic logic [31:0] hex_dec(input logic [6:0] s);
        logic [31:0] r;
        r = (s == BLANK) ? 32'h10 : 32'hFFFF_FFFF;
        for (int v = 0; v < 16; v++) begin
            if (s == hex_enc(4'(v))) r = 32'(v);
        end
        return r;
    endfunction

    logic [6:0]          seg [N_DIGITS];
    logic [6:0]          gseg [N_DIGITS];
    logic                blink_en;
    logic                read_raw;
    logic [N_DIGITS-1:0] blink_mask;
    logic [SW-1:0]       scan_cnt;
    logic [IW-1:0]       idx;
    logic [BW-1:0]       blink_cnt;
    logic                blink_phase;

    logic                hit;
    logic [3:0]          off;
    logic                dig_hit;
    logic                wr;
    logic                rd;
    logic [6:0]          st_pat;
    logic [6:0]          rd_seg;
    logic [31:0]         rd_data;
    logic [6:0]          scan_pick;
    logic                unused_bits;

    assign hit         = (i_lsu_addr[31:6] == BASE_ADDR[31:6]);
    assign off         = i_lsu_addr[5:2];
    assign dig_hit     = ({1'b0, off} < N_DIG5);
    assign wr          = i_lsu_wren & hit;
    assign rd          = i_lsu_rden & hit;
    assign st_pat      = i_st_data[7] ? i_st_data[6:0] : hex_enc(i_st_data[3:0]);
    assign unused_bits = ^{i_lsu_addr[1:0], i_st_data};

    // Register file read mux, evaluated on pre-write state so a same-cycle
    // load and store to one register returns the old value.
    always_comb begin
        rd_seg = BLANK;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (off == 4'(i)) rd_seg = seg[i];
        end
    end

    always_comb begin
        rd_data = 32'h0;
        if (off == CTRL_OFF) begin
            rd_data[0]             = blink_en;
            rd_data[1]             = read_raw;
            rd_data[16+:N_DIGITS]  = blink_mask;
        end else if (dig_hit) begin
            rd_data = read_raw ? {25'b0, rd_seg} : hex_dec(rd_seg);
        end
    end

    // Blink gating shared by the static and scan paths.
    always_comb begin
        scan_pick = BLANK;
        for (int i = 0; i < N_DIGITS; i++) begin
            gseg[i] = (blink_en & blink_mask[i] & blink_phase) ? BLANK : seg[i];
            o_hex_seg[7*i+:7] = gseg[i];
            if (idx == IW'(i)) scan_pick = gseg[i];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_DIGITS; i++) seg[i] <= BLANK;
        end else if (wr) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (off == 4'(i)) seg[i] <= st_pat;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            blink_en   <= 1'b0;
            read_raw   <= 1'b0;
            blink_mask <= '0;
        end else if (wr && off == CTRL_OFF) begin
            blink_en   <= i_st_data[0];
            read_raw   <= i_st_data[1];
            blink_mask <= i_st_data[16+:N_DIGITS];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ld_valid <= 1'b0;
            o_ld_data  <= 32'h0;
        end else begin
            o_ld_valid <= rd;
            o_ld_data  <= rd ? rd_data : 32'h0;
        end
    end

    // Blink timebase free-runs regardless of blink_en.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_scan_an  <= '1;
            o_scan_seg <= BLANK;
        end else begin
            o_scan_an  <= ~(AN_ONE << idx);
            o_scan_seg <= scan_pick;
        end
    end

endmodule

// File: tb/tb_seg7_mmio_ctrl.sv
// tb/tb_seg7_mmio_ctrl.sv - directed self-checking bench for seg7_mmio_ctrl
module tb_seg7_mmio_ctrl;

    localparam logic [31:0] BASE = 32'h0000_7000;
    localparam logic [31:0] CTRL = BASE + 32'h3C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic        wren;
    logic        rden;

    logic [31:0] ld_data,  ld_data3;
    logic        ld_valid, ld_valid3;
    logic [55:0] hex_seg;
    logic [20:0] hex_seg3;
    logic [6:0]  scan_seg, scan_seg3;
    logic [7:0]  scan_an;
    logic [2:0]  scan_an3;

    int tests = 0;
    int fails = 0;
    int ecnt;

    always #5 clk = ~clk;

    seg7_mmio_ctrl #(.N_DIGITS(8), .BASE_ADDR(BASE), .SCAN_DIV(4), .BLINK_DIV(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_lsu_addr(addr), .i_st_data(st_data),
        .i_lsu_wren(wren), .i_lsu_rden(rden), .o_ld_data(ld_data), .o_ld_valid(ld_valid),
        .o_hex_seg(hex_seg), .o_scan_seg(scan_seg), .o_scan_an(scan_an)
    );

    seg7_mmio_ctrl #(.N_DIGITS(3), .BASE_ADDR(BASE), .SCAN_DIV(4), .BLINK_DIV(8)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_lsu_addr(addr), .i_st_data(st_data),
        .i_lsu_wren(wren), .i_lsu_rden(rden), .o_ld_data(ld_data3), .o_ld_valid(ld_valid3),
        .o_hex_seg(hex_seg3), .o_scan_seg(scan_seg3), .o_scan_an(scan_an3)
    );

    // Edges since reset release; the scan and blink timebases are derived from it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        addr = a; st_data = d; wren = 1'b1;
        cyc();
        wren = 1'b0;
    endtask

    task automatic ld(input logic [31:0] a, output logic [31:0] d, output logic v);
        addr = a; rden = 1'b1;
        cyc();
        rden = 1'b0;
        d = ld_data;
        v = ld_valid;
    endtask

    initial begin
        logic [31:0] d;
        logic        v;
        logic [6:0]  pats [3];
        logic [6:0]  e1;
        logic [2:0]  ean3;
        logic [7:0]  ean8;
        int          k;

        rst_n = 1'b0; addr = '0; st_data = '0; wren = 1'b0; rden = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ld", {31'b0, ld_valid, ld_data}, 64'h0);
        chk("rst_hex", {8'h0, hex_seg}, {8'h0, 56'hFF_FFFF_FFFF_FFFF});
        chk("rst_scan", {49'b0, scan_an, scan_seg}, {49'b0, 8'hFF, 7'h7F});
        chk("rst_scan3", {61'b0, scan_an3}, 64'h7);

        rst_n = 1'b1;
        cyc();
        chk("first_scan_an", {56'b0, scan_an}, 64'hFE);

        for (int i = 0; i < 8; i++) begin
            ld(BASE + 32'(4 * i), d, v);
            chk($sformatf("blank_rd%0d", i), {31'b0, v, d}, {31'b0, 1'b1, 32'h10});
        end
        chk("hex_all_blank", {8'h0, hex_seg}, {8'h0, 56'hFF_FFFF_FFFF_FFFF});

        st(BASE + 32'h8, 32'h0000_000A);
        chk("hex_dig2", {57'b0, hex_seg[20:14]}, 64'h08);
        ld(BASE + 32'h8, d, v);
        chk("rd_dig2", {31'b0, v, d}, {31'b0, 1'b1, 32'hA});
        ld(BASE + 32'h9, d, v);
        chk("rd_dig2_lowbits", {31'b0, v, d}, {31'b0, 1'b1, 32'hA});

        st(BASE, 32'h0000_00AB);
        ld(BASE, d, v);
        chk("rd_raw_nonhex", {31'b0, v, d}, {31'b0, 1'b1, 32'hFFFF_FFFF});
        st(CTRL, 32'h2);
        ld(BASE, d, v);
        chk("rd_raw_mode", {31'b0, v, d}, {31'b0, 1'b1, 32'h2B});
        ld(CTRL, d, v);
        chk("rd_ctrl", {31'b0, v, d}, {31'b0, 1'b1, 32'h2});
        st(CTRL, 32'h0);

        st(BASE + 32'h4, 32'h5);
        st(BASE + 32'hC, 32'h3);
        chk("hex_dig3", {57'b0, hex_seg[27:21]}, 64'h30);

        addr = BASE + 32'hC; st_data = 32'h7; wren = 1'b1; rden = 1'b1;
        cyc();
        wren = 1'b0; rden = 1'b0;
        chk("rmw_old", {31'b0, ld_valid, ld_data}, {31'b0, 1'b1, 32'h3});
        ld(BASE + 32'hC, d, v);
        chk("rmw_new", {31'b0, v, d}, {31'b0, 1'b1, 32'h7});
        chk("hex_dig3_new", {57'b0, hex_seg[27:21]}, 64'h78);

        ld(BASE + 32'h20, d, v);
        chk("rd_unmapped", {31'b0, v, d}, {31'b0, 1'b1, 32'h0});
        ld(32'h0000_8000, d, v);
        chk("rd_miss", {31'b0, v, d}, 64'h0);

        pats[0] = 7'h2B; pats[1] = 7'h12; pats[2] = 7'h08;
        for (int n = 0; n < 24; n++) begin
            cyc();
            k    = ecnt;
            ean3 = ~(3'b001 << (((k - 1) / 4) % 3));
            ean8 = ~(8'h01 << (((k - 1) / 4) % 8));
            chk($sformatf("scan3_k%0d", k), {54'b0, scan_an3, scan_seg3},
                {54'b0, ean3, pats[((k - 1) / 4) % 3]});
            chk($sformatf("scan8_an_k%0d", k), {56'b0, scan_an}, {56'b0, ean8});
        end

        st(CTRL, 32'h0002_0001);
        for (int n = 0; n < 20; n++) begin
            cyc();
            e1 = ((ecnt / 8) % 2 == 1) ? 7'h7F : 7'h12;
            chk($sformatf("blink_d1_k%0d", ecnt), {57'b0, hex_seg[13:7]}, {57'b0, e1});
            chk($sformatf("blink_d0_k%0d", ecnt), {57'b0, hex_seg[6:0]}, 64'h2B);
        end
        st(CTRL, 32'h0002_0000);
        chk("blink_off", {57'b0, hex_seg[13:7]}, 64'h12);
        repeat (5) cyc();
        chk("blink_off_hold", {57'b0, hex_seg[13:7]}, 64'h12);
        st(CTRL, 32'h0002_0001);
        for (int n = 0; n < 10; n++) begin
            e1 = ((ecnt / 8) % 2 == 1) ? 7'h7F : 7'h12;
            chk($sformatf("blink_resume_k%0d", ecnt), {57'b0, hex_seg[13:7]}, {57'b0, e1});
            cyc();
        end

        addr = BASE + 32'h4; rden = 1'b1;
        cyc();
        rden = 1'b0;
        chk("preload", {31'b0, ld_valid, ld_data}, {31'b0, 1'b1, 32'h5});
        #2 rst_n = 1'b0;
        #1;
        chk("rst_drop_ld", {31'b0, ld_valid, ld_data}, 64'h0);
        chk("rst_mid_hex", {8'h0, hex_seg}, {8'h0, 56'hFF_FFFF_FFFF_FFFF});
        chk("rst_mid_scan", {56'b0, scan_an}, 64'hFF);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("rel_scan_an", {53'b0, scan_an, scan_an3}, {53'b0, 8'hFE, 3'b110});
        chk("rel_ld", {31'b0, ld_valid, ld_data}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_mmio_ctrl.md
Name: seg7_mmio_ctrl

Overview:
- Memory-mapped seven-segment display peripheral on the LSU bus.
- Holds N_DIGITS segment registers, written either as a hex nibble (hardware-encoded) or as a raw pattern.
- Load reads return either the decoded hex value or the raw pattern, with one-cycle registered latency.
- Drives static per-digit outputs plus a time-multiplexed scan output, with per-digit blink.

Parameters:
- N_DIGITS, 8, number of digits; legal range 1..15.
- BASE_ADDR, 32'h0000_7000, 64-byte-aligned window base.
- SCAN_DIV, 50000, clock cycles each digit is held active in scan mode; must be >= 1.
- BLINK_DIV, 25000000, clock cycles per blink phase; must be >= 1.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_lsu_addr  in  32  byte address
- i_st_data  in  32  store data
- i_lsu_wren  in  1  store strobe, one word per cycle
- i_lsu_rden  in  1  load strobe
- o_ld_data  out  32  load data, valid with o_ld_valid
- o_ld_valid  out  1  one-cycle pulse; window hit load response
- o_hex_seg  out  7*N_DIGITS  static segments, active-low; digit i at [7i+6:7i]
- o_scan_seg  out  7  multiplexed segments, active-low
- o_scan_an  out  N_DIGITS  digit enables, active-low, one-hot

Behaviour:
- Window hit: i_lsu_addr[31:6] == BASE_ADDR[31:6]. Word offset off = i_lsu_addr[5:2]; bits [1:0] ignored; full-word access only.
- off < N_DIGITS: digit register off (7 bits).
- off == 15: CTRL register.
  - bit0 blink_en
  - bit1 read_raw
  - bits[16+N_DIGITS-1:16] blink_mask
  - other bits read as 0.
- Any other off: writes ignored, reads return 0 with o_ld_valid=1.
- Store to digit:
  - i_st_data[7]=1: seg <= i_st_data[6:0].
  - i_st_data[7]=0: seg <= hex encode of i_st_data[3:0]:
    - 0..9: 40,79,24,30,19,12,02,78,00,10
    - A..F: 08,03,46,21,06,0E
  - Stored on the clock edge when i_lsu_wren is high.
- Load: registered. If i_lsu_rden is high and the address hits in cycle N, then in cycle N+1 o_ld_valid=1 and o_ld_data holds the response.
  - Address miss: o_ld_valid=0 and o_ld_data=0.
- Digit read, read_raw=1: {25'b0, seg}.
- Digit read, read_raw=0:
  - Hex-table pattern: its value 0..15.
  - 7'h7F (blank): 32'h10.
  - Any other pattern: 32'hFFFF_FFFF.
- Simultaneous load and store to the same register in one cycle: the load returns the pre-write value; the store takes effect.
- Blink: blink counter counts 0..BLINK_DIV-1, then wraps. blink_phase toggles on each wrap.
  - When blink_en & blink_mask[i] & blink_phase, digit i outputs 7'h7F on both o_hex_seg and the scan path.
  - Clearing blink_en shows all digits on the next cycle.
  - Clearing blink_en does not reset the blink counter or blink_phase.
- Scan: scan counter counts 0..SCAN_DIV-1. On its terminal count, idx <= (idx == N_DIGITS-1) ? 0 : idx+1.
  - o_scan_an and o_scan_seg are registered from idx and the gated seg[idx]. They update one cycle after idx changes.
  - A store to the digit currently being scanned appears on o_scan_seg two cycles after the store cycle.
  - N_DIGITS=1: idx stays 0.
- o_hex_seg is registered and updates the cycle after a store.
- Reset, asynchronous, all outputs and state:
  - All digit registers 7'h7F.
  - CTRL 0.
  - idx 0; scan and blink counters 0; blink_phase 0.
  - o_ld_data 0, o_ld_valid 0.
  - o_hex_seg all 1s, o_scan_seg 7'h7F, o_scan_an all 1s.
  - First scan output after reset: o_scan_an = ~1 on the first clock edge after reset release.
  - Reset mid-load: the pending response is dropped.

Test Plan:
- Reset, then read each digit with read_raw=0 -> o_ld_data=32'h10 one cycle after each rden; o_hex_seg all 1s.
- Store 0x0000_000A to digit 2 -> o_hex_seg[20:14]=7'h08 next cycle; read digit 2 -> 32'hA.
- Store 0x0000_00AB (raw 7'h2B) to digit 0 -> read returns 32'hFFFF_FFFF. Set CTRL=0x2, reread -> 32'h2B.
- SCAN_DIV=4, N_DIGITS=3 -> o_scan_an cycles 110,101,011 with each value held 4 cycles, wrapping to 110. o_scan_seg matches the digit.
- BLINK_DIV=8, CTRL={mask=0b010, blink_en=1} -> digit 1 alternates between its pattern and 7'h7F every 8 cycles; other digits steady.
- Same-cycle load+store to digit 3 -> load returns the old value; a following load returns the new value. Load at offset 0x20 with N_DIGITS=8 -> 0 with valid; address outside the window -> no o_ld_valid.
